// File: rtl/edge_event_capture.sv
// edge_event_capture: per-channel synchronised rise/fall detector with W1C sticky status and masked irq.
// Define EDGE_EVENT_COUNT_EN to build per-channel saturating event counters with cnt_sel readback.
module edge_event_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  localparam int SEL_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] clear,
  input  logic [DATA_WIDTH-1:0] irq_en,
  output logic [DATA_WIDTH-1:0] edge_out,
  output logic [DATA_WIDTH-1:0] status,
  output logic                  irq,
  input  logic [SEL_W-1:0]      cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out
);

  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_p1;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] det;
  logic [WARM_W-1:0]     warm;

  // Stage p1 compare: the newest synchronised sample against the previous one.
  always_comb begin
    rise = sync_p0[SYNC_STAGES-1] & ~prev_p1;
    fall = ~sync_p0[SYNC_STAGES-1] & prev_p1;
    det  = '0;
    if (warm == '0) begin
      unique case (mode)
        2'b01:   det = rise;
        2'b10:   det = fall;
        2'b11:   det = rise | fall;
        default: det = '0;
      endcase
    end
  end

  // Warm-up hides the reset-zeroed chain filling with live data, so levels held through reset stay silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
      prev_p1  <= '0;
      edge_out <= '0;
      status   <= '0;
      irq      <= 1'b0;
      warm     <= WARM_INIT;
    end else begin
      sync_p0[0] <= data_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
      prev_p1  <= sync_p0[SYNC_STAGES-1];
      edge_out <= det;
      status   <= (status & ~clear) | edge_out;
      irq      <= |(status & irq_en);
      if (warm != '0) warm <= warm - WARM_W'(1);
    end
  end

`ifdef EDGE_EVENT_COUNT_EN
  logic [CNT_WIDTH-1:0] count [DATA_WIDTH];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p3 counters follow edge_out; readback adds one more register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DATA_WIDTH; i++) count[i] <= '0;
      cnt_out <= '0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (clear[i])         count[i] <= CNT_WIDTH'(edge_out[i]);
        else if (edge_out[i]) count[i] <= sat_inc(count[i]);
      end
      if ({1'b0, cnt_sel} < (SEL_W+1)'(DATA_WIDTH)) cnt_out <= count[cnt_sel];
      else                                          cnt_out <= '0;
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_edge_event_capture.sv
// Bench for edge_event_capture: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_edge_event_capture;
  localparam int W    = 8;
  localparam int N    = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef EDGE_EVENT_COUNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic [1:0]    mode;
  logic [W-1:0]  clear;
  logic [W-1:0]  irq_en;
  logic [W-1:0]  edge_out;
  logic [W-1:0]  status;
  logic          irq;
  logic [2:0]    cnt_sel;
  logic [CW-1:0] cnt_out;

  always #5 clk = ~clk;

  edge_event_capture #(.DATA_WIDTH(W), .SYNC_STAGES(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .clear(clear),
    .irq_en(irq_en), .edge_out(edge_out), .status(status), .irq(irq),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: edge_out after edge k compares the inputs sampled N and N+1 edges earlier,
  // unless edge k lies within N+1 edges of the most recent reset edge.
  initial begin : model
    logic [W-1:0]  dh [64];
    logic [W-1:0]  n_edge, d_old, d_new;
    logic [W-1:0]  m_edge, m_status;
    logic          m_irq;
    logic [CW-1:0] m_cnt_out;
    int            m_cnt [W];
    int            k, last_rst, sel;
    k = 0; last_rst = 0;
    m_edge = '0; m_status = '0; m_irq = 1'b0; m_cnt_out = '0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk);
      dh[k & 63] = data_in;
      if (reset) last_rst = k;
      n_edge = '0;
      if (!reset && (k - last_rst > N + 1)) begin
        d_old = dh[(k - N - 1) & 63];
        d_new = dh[(k - N) & 63];
        case (mode)
          2'b01:   n_edge = d_new & ~d_old;
          2'b10:   n_edge = d_old & ~d_new;
          2'b11:   n_edge = d_new ^ d_old;
          default: n_edge = '0;
        endcase
      end
      sel = int'(cnt_sel);
      if (reset) begin
        m_status = '0; m_irq = 1'b0; m_cnt_out = '0;
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
      end else begin
        m_cnt_out = (HAS_CNT && sel < W) ? CW'(m_cnt[sel]) : '0;
        m_irq     = |(m_status & irq_en);
        m_status  = (m_status & ~clear) | m_edge;
        for (int i = 0; i < W; i++) begin
          if (clear[i])       m_cnt[i] = m_edge[i] ? 1 : 0;
          else if (m_edge[i]) m_cnt[i] = (m_cnt[i] >= CMAX) ? CMAX : m_cnt[i] + 1;
        end
      end
      m_edge = n_edge;
      @(negedge clk);
      check($sformatf("edge_out@%0d", k), 32'(edge_out), 32'(m_edge));
      check($sformatf("status@%0d", k),   32'(status),   32'(m_status));
      check($sformatf("irq@%0d", k),      32'(irq),      32'(m_irq));
      check($sformatf("cnt_out@%0d", k),  32'(cnt_out),  32'(m_cnt_out));
      k++;
    end
  end

  initial begin : stim
    logic [W-1:0]  seen;
    logic          irq_seen;
    logic [CW-1:0] exp_sat;
    int            pulses;
    exp_sat = HAS_CNT ? CW'(CMAX) : '0;

    // 1: inputs high through reset must not produce events
    reset = 1'b1; data_in = 8'hFF; mode = 2'b11; clear = '0; irq_en = 8'hFF; cnt_sel = '0;
    repeat (3) tick();
    check("reset edge_out", 32'(edge_out), 32'h0);
    check("reset status",   32'(status),   32'h0);
    check("reset irq",      32'(irq),      32'h0);
    check("reset cnt_out",  32'(cnt_out),  32'h0);
    reset = 1'b0;
    seen = '0; irq_seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | edge_out | status;
      irq_seen = irq_seen | irq;
    end
    check("t1 no events", 32'(seen),     32'h0);
    check("t1 no irq",    32'(irq_seen), 32'h0);

    // 2: rise on ch0, latency N+1 edges, status then irq
    mode = 2'b00; data_in = 8'h00;
    repeat (6) tick();
    clear = 8'hFF; tick(); clear = '0;
    irq_en = 8'h01; mode = 2'b01; data_in = 8'h01;
    tick(); check("t2 edge T0",   32'(edge_out), 32'h00);
    tick(); check("t2 edge T0+1", 32'(edge_out), 32'h00);
    tick(); check("t2 edge T0+2", 32'(edge_out), 32'h01);
            check("t2 status early", 32'(status), 32'h00);
    tick(); check("t2 pulse ends", 32'(edge_out), 32'h00);
            check("t2 status",     32'(status),   32'h01);
            check("t2 irq early",  32'(irq),      32'h0);
    tick(); check("t2 irq",        32'(irq),      32'h1);

    // 3: fall mode, ch3 falls while ch4 rises
    mode = 2'b00; data_in = 8'h09;
    repeat (6) tick();
    clear = 8'hFF; tick(); clear = '0;
    mode = 2'b10; data_in = 8'h11;
    repeat (3) tick();
    check("t3 edge fall only", 32'(edge_out), 32'h08);
    tick(); check("t3 status", 32'(status), 32'h08);

    // 4: set beats simultaneous clear; clear alone drops status then irq
    irq_en = 8'h04; mode = 2'b11; data_in = 8'h15;
    repeat (3) tick();
    check("t4 first pulse", 32'(edge_out), 32'h04);
    tick(); check("t4 status set", 32'(status & 8'h04), 32'h04);
    data_in = 8'h11;
    repeat (3) tick();
    check("t4 second pulse", 32'(edge_out), 32'h04);
    clear = 8'h04;
    tick(); check("t4 set wins", 32'(status & 8'h04), 32'h04);
    tick(); check("t4 cleared",  32'(status & 8'h04), 32'h00);
            check("t4 irq lags", 32'(irq), 32'h1);
    clear = '0;
    tick(); check("t4 irq off", 32'(irq), 32'h0);

    // 5: ch0 toggling every cycle, counter saturation and clear
    clear = 8'hFF; tick(); clear = '0;
    cnt_sel = 3'd0; mode = 2'b11; pulses = 0;
    repeat (300) begin
      data_in[0] = ~data_in[0];
      tick();
      if (edge_out[0]) pulses++;
    end
    repeat (3) begin
      tick();
      if (edge_out[0]) pulses++;
    end
    check("t5 pulse per toggle", 32'(pulses), 32'd300);
    repeat (3) tick();
    check("t5 saturated", 32'(cnt_out), 32'(exp_sat));
    clear = 8'h01;
    tick(); check("t5 read latency", 32'(cnt_out), 32'(exp_sat));
    clear = '0;
    tick(); check("t5 cleared", 32'(cnt_out), 32'h0);

    // 6: reset while a ch1 rise is inside the synchroniser
    data_in = 8'h13;
    tick();
    reset = 1'b1;
    tick();
    check("t6 status reset", 32'(status), 32'h0);
    reset = 1'b0;
    seen = '0;
    repeat (12) begin
      tick();
      seen = seen | edge_out;
    end
    check("t6 no pulse", 32'(seen), 32'h0);
    data_in = 8'h11;
    repeat (3) tick();
    check("t6 after warm-up", 32'(edge_out), 32'h02);

    // Randomized traffic, checked every cycle by the model
    repeat (1500) begin
      data_in = data_in ^ (W'($urandom) & W'($urandom));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) irq_en = W'($urandom);
      clear   = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      cnt_sel = 3'($urandom);
      reset   = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; clear = '0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
